// File: rtl/cpu_pkg.sv
// Shared core definitions.
//   PCSEL_* : PC-select codes, common to the PC-mux select stage, the
//             decoder and the fetch unit.
//   fetch_state_t : fetch sequencer state (FETCH waits for imem_ack,
//             HOLD waits for decode to take the instruction).
package cpu_pkg;

  localparam logic [1:0] PCSEL_SEQ    = 2'd0;
  localparam logic [1:0] PCSEL_JUMP   = 2'd1;
  localparam logic [1:0] PCSEL_BRANCH = 2'd2;
  localparam logic [1:0] PCSEL_REG    = 2'd3;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC calculation. It is also used by the branch-target
// checker, so it has no state and no knowledge of the fetch handshake.
//   pcsel         : PC-select code (see cpu_pkg PCSEL_*)
//   if_pc         : address of the instruction being retired from fetch
//   jump_target   : absolute target, pcsel = JUMP
//   branch_offset : signed byte offset from if_pc, pcsel = BRANCH
//   reg_target    : register-indirect target, pcsel = REG
//   next_pc       : selected target, word aligned (bits [1:0] are zero)
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [1:0]    pcsel,
  input  logic [AW-1:0] if_pc,
  input  logic [AW-1:0] jump_target,
  input  logic [AW-1:0] branch_offset,
  input  logic [AW-1:0] reg_target,
  output logic [AW-1:0] next_pc
);

  logic [AW-1:0] raw_pc;

  // Additions are AW bits wide and wrap silently; a negative offset in
  // two's complement therefore subtracts without any sign handling.
  always_comb begin
    raw_pc = if_pc + AW'(4);
    case (pcsel)
      PCSEL_SEQ:    raw_pc = if_pc + AW'(4);
      PCSEL_JUMP:   raw_pc = jump_target;
      PCSEL_BRANCH: raw_pc = if_pc + branch_offset;
      PCSEL_REG:    raw_pc = reg_target;
      default:      raw_pc = if_pc + AW'(4);
    endcase
  end

  // Alignment is applied to every source, including register targets.
  assign next_pc = raw_pc & ~AW'(3);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
//
// Handshakes:
//   imem: imem_req is high for the whole FETCH state with imem_addr = pc held
//         stable; the cycle imem_ack is high (and imem_req is high) the data on
//         imem_rdata is captured. imem_ack without imem_req is ignored. The
//         ack may come in the same cycle the request rises.
//   if:   if_valid is high for the whole HOLD state with if_instr/if_pc held
//         stable; the instruction transfers in a cycle where if_valid and
//         if_ready are both high. pcsel and the targets are sampled only then.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   pcsel, jump_target, branch_offset, reg_target : next-PC selection
//   imem_req, imem_addr, imem_ack, imem_rdata     : instruction memory
//   if_valid, if_ready, if_instr, if_pc           : output to decode
//
// The sequencer state is state_q (cpu_pkg::fetch_state_t).
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            IW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    pcsel,
  input  logic [AW-1:0] jump_target,
  input  logic [AW-1:0] branch_offset,
  input  logic [AW-1:0] reg_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] ifpc_q, ifpc_d;
  logic [AW-1:0] next_pc;

  pc_next_calc #(.AW(AW)) u_next (
    .pcsel         (pcsel),
    .if_pc         (ifpc_q),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .next_pc       (next_pc)
  );

  // Gating with rst keeps both handshakes quiet for the whole reset pulse,
  // including the first cycle before any reset edge has been seen.
  assign imem_req  = (state_q == FETCH) && !rst;
  assign if_valid  = (state_q == HOLD) && !rst;
  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (if_ready) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset takes priority, so an ack arriving with rst high is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ifpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    pcsel;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] branch_offset;
  logic [AW-1:0] reg_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          if_valid;
  logic          if_ready;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] exp_pc_q[$];
  logic [IW-1:0] exp_instr_q[$];

  pc_fetch_unit #(.AW(AW), .IW(IW), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .pcsel         (pcsel),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  // Request monitor: on each accepted memory transfer, compare the address.
  always @(negedge clk) begin
    if (!rst && imem_req && imem_ack) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_request", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("imem_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
      end
    end
  end

  // Output monitor: compare each newly presented instruction once.
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (if_valid && !seen) begin
        if (exp_pc_q.size() == 0) begin
          chk("unexpected_if_valid", 64'(if_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("if_pc", 64'(if_pc), 64'(exp_pc_q.pop_front()));
          chk("if_instr", 64'(if_instr), 64'(exp_instr_q.pop_front()));
        end
        seen = 1'b1;
      end
      if (if_valid && if_ready) seen = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // One full instruction: request at exp_addr, memory waits wait_n cycles
  // before acking with rdata, then decode stalls stall_n cycles (with stray
  // acks) before accepting with the given next-PC selection.
  task automatic step(input logic [AW-1:0] exp_addr, input logic [IW-1:0] rdata,
                      input int wait_n, input int stall_n, input logic [1:0] sel,
                      input logic [AW-1:0] jt, input logic [AW-1:0] bo,
                      input logic [AW-1:0] rt);
    int guard;
    // New request must already be up: one cycle after accept / reset release.
    chk("req_on_entry", 64'(imem_req), 64'd1);
    guard = 0;
    while (!imem_req && guard < 20) begin
      next_cycle();
      guard++;
    end
    if (!imem_req) begin
      chk("req_timeout", 64'(imem_req), 64'd1);
      return;
    end
    exp_addr_q.push_back(exp_addr);
    exp_pc_q.push_back(exp_addr);
    exp_instr_q.push_back(rdata);
    for (int i = 0; i < wait_n; i++) begin
      imem_ack = 1'b0;
      chk("wait_addr_stable", 64'(imem_addr), 64'(exp_addr));
      chk("wait_no_valid", 64'(if_valid), 64'd0);
      next_cycle();
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    next_cycle();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid_after_ack", 64'(if_valid), 64'd1);
    chk("req_low_in_hold", 64'(imem_req), 64'd0);
    for (int i = 0; i < stall_n; i++) begin
      if_ready   = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      next_cycle();
      chk("stall_instr", 64'(if_instr), 64'(rdata));
      chk("stall_pc", 64'(if_pc), 64'(exp_addr));
      chk("stall_req", 64'(imem_req), 64'd0);
      chk("stall_valid", 64'(if_valid), 64'd1);
    end
    imem_ack      = 1'b0;
    pcsel         = sel;
    jump_target   = jt;
    branch_offset = bo;
    reg_target    = rt;
    if_ready      = 1'b1;
    next_cycle();
    if_ready      = 1'b0;
    pcsel         = 2'($urandom_range(0, 3));
    jump_target   = $urandom;
    branch_offset = $urandom;
    reg_target    = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    pcsel = PCSEL_SEQ;
    jump_target = '0;
    branch_offset = '0;
    reg_target = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    if_ready = 1'b0;

    // Reset for 3 cycles with stray acks.
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'(i & 1);
      next_cycle();
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_valid", 64'(if_valid), 64'd0);
    end
    imem_ack = 1'b0;
    chk("rst_if_pc", 64'(if_pc), 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    rst = 1'b0;
    #1;
    chk("first_addr", 64'(imem_addr), 64'd0);

    // Sequential stream.
    step(32'h0,   32'h1111_1111, 0, 0, PCSEL_SEQ, '0, '0, '0);
    step(32'h4,   32'h2222_0004, 0, 0, PCSEL_SEQ, '0, '0, '0);
    step(32'h8,   32'h2222_0008, 0, 0, PCSEL_SEQ, '0, '0, '0);
    step(32'hC,   32'h2222_000C, 0, 0, PCSEL_JUMP, 32'h100, '0, '0);
    // Redirects from 0x100.
    step(32'h100, 32'h3333_0100, 0, 0, PCSEL_JUMP, 32'h400, '0, '0);
    step(32'h400, 32'h3333_0400, 0, 0, PCSEL_JUMP, 32'h100, '0, '0);
    step(32'h100, 32'h3333_0101, 0, 0, PCSEL_BRANCH, '0, 32'hFFFF_FFF8, '0);
    step(32'hF8,  32'h3333_00F8, 0, 0, PCSEL_JUMP, 32'h100, '0, '0);
    step(32'h100, 32'h3333_0102, 0, 0, PCSEL_REG, '0, '0, 32'h203);
    // Memory wait then decode back-pressure; leave toward the wrap point.
    step(32'h200, 32'h4444_0200, 3, 5, PCSEL_JUMP, 32'hFFFF_FFFC, '0, '0);
    step(32'hFFFF_FFFC, 32'h5555_FFFC, 0, 0, PCSEL_SEQ, '0, '0, '0);
    step(32'h0,   32'h5555_0000, 1, 0, PCSEL_SEQ, '0, '0, '0);

    // Reset while fetching 0x4, with an ack in the same cycle.
    chk("pre_rst_req", 64'(imem_req), 64'd1);
    chk("pre_rst_addr", 64'(imem_addr), 64'h4);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("mid_rst_req", 64'(imem_req), 64'd0);
    next_cycle();
    chk("mid_rst_valid", 64'(if_valid), 64'd0);
    next_cycle();
    imem_ack = 1'b0;
    chk("mid_rst_if_pc", 64'(if_pc), 64'd0);
    chk("mid_rst_if_instr", 64'(if_instr), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 64'(if_valid), 64'd0);
    chk("post_rst_addr", 64'(imem_addr), 64'd0);
    step(32'h0, 32'h6666_0000, 0, 0, PCSEL_SEQ, '0, '0, '0);

    repeat (3) next_cycle();
    chk("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    chk("out_q_empty", 64'(exp_pc_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
